// File: rtl/axi_wr_dma.sv
// AXI write master: drains a data stream into memory as INCR bursts of up to MAX_BURST beats.
// Optional macro AXI_WR_DMA_4KB_SPLIT_EN keeps every burst inside a 4 KB page.
module axi_wr_dma #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned AXI_ID     = 0,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [15:0]             beat_cnt_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [ID_WIDTH-1:0]     wid,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned SIZE       = $clog2(STRB_WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]            state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;
    logic [15:0]           remaining, remaining_nxt;
    logic [4:0]            len, len_nxt, len_calc;
    logic [3:0]            beat_cnt, beat_cnt_nxt;
    logic                  awvalid_nxt, busy_nxt, done_nxt, err_nxt, bready_nxt;
    logic [ADDR_WIDTH-1:0] awaddr_nxt;
    logic [3:0]            awlen_nxt;
    logic                  unused_bid;

    assign unused_bid = ^bid;

    // Constant channel attributes and the W-phase stream pass-through
    assign awid      = ID_WIDTH'(AXI_ID);
    assign wid       = ID_WIDTH'(AXI_ID);
    assign awsize    = 3'(SIZE);
    assign awburst   = 2'b01;
    assign wstrb     = '1;
    assign wdata     = s_data_i;
    assign wvalid    = (state == S_W) & s_valid_i;
    assign s_ready_o = (state == S_W) & wready;
    assign wlast     = wvalid & (beat_cnt == 4'(len - 5'd1));

    // Length of the next burst
`ifdef AXI_WR_DMA_4KB_SPLIT_EN
    logic [12:0] page_beats;
    always_comb begin
        len_calc   = (remaining < 16'(MAX_BURST)) ? 5'(remaining) : 5'(MAX_BURST);
        page_beats = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE;
        if (13'(len_calc) > page_beats) begin
            len_calc = 5'(page_beats);
        end
    end
`else
    always_comb begin
        len_calc = (remaining < 16'(MAX_BURST)) ? 5'(remaining) : 5'(MAX_BURST);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            len       <= '0;
            beat_cnt  <= '0;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            awlen     <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            bready    <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            remaining <= remaining_nxt;
            len       <= len_nxt;
            beat_cnt  <= beat_cnt_nxt;
            awvalid   <= awvalid_nxt;
            awaddr    <= awaddr_nxt;
            awlen     <= awlen_nxt;
            busy_o    <= busy_nxt;
            done_o    <= done_nxt;
            err_o     <= err_nxt;
            bready    <= bready_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        len_nxt       = len;
        beat_cnt_nxt  = beat_cnt;
        awvalid_nxt   = awvalid;
        awaddr_nxt    = awaddr;
        awlen_nxt     = awlen;
        err_nxt       = err_o;

        case (state)
            S_IDLE: begin
                if (start_i) begin
                    addr_nxt      = base_addr_i;
                    remaining_nxt = beat_cnt_i;
                    err_nxt       = 1'b0;
                    state_nxt     = (beat_cnt_i == 16'd0) ? S_DONE : S_AW;
                end
            end
            S_AW: begin
                // First AW cycle loads the burst fields; they hold until awready
                if (!awvalid) begin
                    awvalid_nxt = 1'b1;
                    awaddr_nxt  = addr;
                    awlen_nxt   = 4'(len_calc - 5'd1);
                    len_nxt     = len_calc;
                end else if (awready) begin
                    awvalid_nxt  = 1'b0;
                    beat_cnt_nxt = '0;
                    state_nxt    = S_W;
                end
            end
            S_W: begin
                if (wvalid && wready) begin
                    beat_cnt_nxt = beat_cnt + 4'd1;
                    if (wlast) begin
                        remaining_nxt = remaining - 16'(len);
                        addr_nxt      = addr + (ADDR_WIDTH'(len) << SIZE);
                        state_nxt     = S_B;
                    end
                end
            end
            S_B: begin
                if (bvalid) begin
                    if (bresp != 2'b00) begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = (remaining == 16'd0) ? S_DONE : S_AW;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt   = (state_nxt == S_AW) || (state_nxt == S_W) || (state_nxt == S_B);
        done_nxt   = (state_nxt == S_DONE);
        bready_nxt = (state_nxt == S_B);
    end

endmodule

// File: tb/tb_axi_wr_dma.sv
// Self-checking bench for axi_wr_dma: table of commands with a responding AXI slave and stream source.
module tb_axi_wr_dma;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [31:0]  base_addr_i;
    logic [15:0]  beat_cnt_i;
    logic         busy_o, done_o, err_o;
    logic         s_valid_i, s_ready_o;
    logic [127:0] s_data_i;
    logic         awvalid, awready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [3:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         wvalid, wready;
    logic [3:0]   wid;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast;
    logic         bvalid, bready;
    logic [3:0]   bid;
    logic [1:0]   bresp;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_wr_dma dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .beat_cnt_i(beat_cnt_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
    );

    typedef struct {
        logic [31:0]       base;
        logic [15:0]       beats;
        int                aw_delay;
        bit                wtog;
        bit                sgap;
        int                err_burst;
        int                abort_at;
        int                exp_n;
        logic [2:0][31:0]  exp_addr;
        logic [2:0][3:0]   exp_len;
        bit                exp_err;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] base, input logic [15:0] beats,
                                input int awd, input bit wtog, input bit sgap,
                                input int errb, input int abort_at, input int n,
                                input logic [31:0] a0, input logic [3:0] l0,
                                input logic [31:0] a1, input logic [3:0] l1,
                                input logic [31:0] a2, input logic [3:0] l2,
                                input bit err);
        vec_t v;
        v.base = base; v.beats = beats; v.aw_delay = awd; v.wtog = wtog; v.sgap = sgap;
        v.err_burst = errb; v.abort_at = abort_at; v.exp_n = n;
        v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2;
        v.exp_len[0] = l0;  v.exp_len[1] = l1;  v.exp_len[2] = l2;
        v.exp_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " awvalid"}, 64'(awvalid), 64'd0);
        chk({tag, " wvalid"},  64'(wvalid), 64'd0);
        chk({tag, " s_ready"}, 64'(s_ready_o), 64'd0);
        chk({tag, " bready"},  64'(bready), 64'd0);
        chk({tag, " busy"},    64'(busy_o), 64'd0);
        chk({tag, " done"},    64'(done_o), 64'd0);
        chk({tag, " err"},     64'(err_o), 64'd0);
        chk({tag, " awaddr"},  64'(awaddr), 64'd0);
        chk({tag, " awlen"},   64'(awlen), 64'd0);
        chk({tag, " wlast"},   64'(wlast), 64'd0);
        chk({tag, " awsize"},  64'(awsize), 64'd4);
        chk({tag, " awburst"}, 64'(awburst), 64'd1);
        chk({tag, " wstrb"},   64'(wstrb), 64'hFFFF);
        chk({tag, " awid/wid"}, 64'({awid, wid}), 64'd0);
    endtask

    task automatic idle_inputs();
        awready = 1'b0; wready = 1'b0; s_valid_i = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    endtask

    // Issue one command and act as stream source plus AXI slave until done (or abort point)
    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] oa [8];
        logic [3:0]  ol [8];
        int nb = 0, aw_hs = 0, b_hs = 0, aw_wait = 0, b_idx = 0;
        int beats_seen = 0, beat_in = 0, ndone = 0, done_cyc = -1, post = 0;
        int proto_bad = 0, data_bad = 0, busy_bad = 0, err_bad = 0;
        logic [31:0] data_src = 32'd0, pa = 32'd0;
        logic [3:0]  cur_len = 4'd0, pl = 4'd0;
        bit in_w = 0, pend_b = 0, aw_stall = 0, err_m = 0, err_done = 0, exp_busy, last;
        string t;
        t = $sformatf("v%0d", idx);

        @(negedge clk);
        start_i = 1'b1; base_addr_i = v.base; beat_cnt_i = v.beats;
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            awready   = (aw_wait >= v.aw_delay);
            wready    = v.wtog ? (cyc % 2 == 1) : 1'b1;
            s_valid_i = v.sgap ? (cyc % 3 != 0) : 1'b1;
            s_data_i  = {4{data_src}};
            bvalid    = pend_b;
            bresp     = (b_idx == v.err_burst) ? 2'b10 : 2'b00;
            #1;
            if (v.abort_at != 0 && cyc == v.abort_at) return;

            if (err_o !== err_m) err_bad++;
            exp_busy = (v.beats != 16'd0) && (ndone == 0) && !done_o;
            if (busy_o !== exp_busy) busy_bad++;
            if (done_o === 1'b1) begin
                ndone++; done_cyc = cyc; err_done = err_o;
            end
            last = (beat_in == int'(cur_len));
            if (wvalid !== (in_w && s_valid_i)) proto_bad++;
            if (s_ready_o !== (in_w && wready)) proto_bad++;
            if (wlast !== (in_w && s_valid_i && last)) proto_bad++;
            if (bready !== pend_b) proto_bad++;
            if (awvalid && (aw_hs > b_hs)) proto_bad++;
            if (awvalid && aw_stall && (awaddr !== pa || awlen !== pl)) proto_bad++;

            if (awvalid && awready) begin
                if (nb < 8) begin oa[nb] = awaddr; ol[nb] = awlen; end
                nb++; aw_hs++; cur_len = awlen; in_w = 1; beat_in = 0; aw_wait = 0; aw_stall = 0;
            end else if (awvalid) begin
                aw_wait++; aw_stall = 1; pa = awaddr; pl = awlen;
            end else begin
                aw_stall = 0;
            end
            if (wvalid && wready) begin
                if (wdata !== {4{beats_seen[31:0]}}) data_bad++;
                beats_seen++;
                if (last) begin in_w = 0; pend_b = 1; end
                else beat_in++;
            end
            if (s_valid_i && s_ready_o) data_src++;
            if (bvalid && bready) begin
                if (bresp != 2'b00) err_m = 1;
                pend_b = 0; b_idx++; b_hs++;
            end
            if (ndone > 0) post++;
            if (post > 3) break;
            @(negedge clk);
        end
        idle_inputs();

        chk({t, " done pulses"}, 64'(ndone), 64'd1);
        chk({t, " bursts"}, 64'(nb), 64'(v.exp_n));
        for (int i = 0; i < v.exp_n && i < nb && i < 3; i++) begin
            chk($sformatf("%s awaddr%0d", t, i), 64'(oa[i]), 64'(v.exp_addr[i]));
            chk($sformatf("%s awlen%0d", t, i), 64'(ol[i]), 64'(v.exp_len[i]));
        end
        chk({t, " beats written"}, 64'(beats_seen), 64'(v.beats));
        chk({t, " protocol errs"}, 64'(proto_bad), 64'd0);
        chk({t, " data order errs"}, 64'(data_bad), 64'd0);
        chk({t, " busy errs"}, 64'(busy_bad), 64'd0);
        chk({t, " err_o track errs"}, 64'(err_bad), 64'd0);
        chk({t, " err_o at done"}, 64'(err_done), 64'(v.exp_err));
        if (v.beats == 16'd0) chk({t, " done latency ok"}, 64'(done_cyc >= 0 && done_cyc <= 1), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [6];
        vec_t abort_v, post_v;
        vecs[0] = mk(32'h1000, 16'd40, 0, 0, 0, -1, 0, 3,
                     32'h1000, 4'd15, 32'h1100, 4'd15, 32'h1200, 4'd7, 0);
        vecs[1] = mk(32'h1000, 16'd0, 0, 0, 0, -1, 0, 0,
                     32'h0, 4'd0, 32'h0, 4'd0, 32'h0, 4'd0, 0);
        vecs[2] = mk(32'h2000, 16'd20, 5, 1, 1, -1, 0, 2,
                     32'h2000, 4'd15, 32'h2100, 4'd3, 32'h0, 4'd0, 0);
        vecs[3] = mk(32'h4000, 16'd48, 0, 0, 0, 1, 0, 3,
                     32'h4000, 4'd15, 32'h4100, 4'd15, 32'h4200, 4'd15, 1);
`ifdef AXI_WR_DMA_4KB_SPLIT_EN
        vecs[4] = mk(32'h0FC0, 16'd8, 0, 0, 0, -1, 0, 2,
                     32'h0FC0, 4'd3, 32'h1000, 4'd3, 32'h0, 4'd0, 0);
`else
        vecs[4] = mk(32'h0FC0, 16'd8, 0, 0, 0, -1, 0, 1,
                     32'h0FC0, 4'd7, 32'h0, 4'd0, 32'h0, 4'd0, 0);
`endif
        vecs[5] = mk(32'h0010, 16'd17, 1, 0, 0, -1, 0, 2,
                     32'h0010, 4'd15, 32'h0110, 4'd0, 32'h0, 4'd0, 0);
        abort_v = mk(32'h1000, 16'd40, 0, 0, 0, -1, 8, 0,
                     32'h0, 4'd0, 32'h0, 4'd0, 32'h0, 4'd0, 0);
        post_v  = mk(32'h3000, 16'd4, 2, 0, 0, -1, 0, 1,
                     32'h3000, 4'd3, 32'h0, 4'd0, 32'h0, 4'd0, 0);

        rst = 1'b1; start_i = 1'b0; base_addr_i = '0; beat_cnt_i = '0;
        s_data_i = '0; bid = '0;
        idle_inputs();
        s_valid_i = 1'b1; wready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset("reset");
        idle_inputs();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset during the first burst's data phase, then a fresh command
        run_vec(6, abort_v);
        rst = 1'b1; s_valid_i = 1'b1; wready = 1'b1; awready = 1'b0; bvalid = 1'b0;
        @(negedge clk);
        #1;
        check_reset("midreset");
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post-reset idle done%0d", i), 64'(done_o), 64'd0);
        end
        run_vec(7, post_v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
